// File: rtl/uart_wb_rc_bridge_if.sv
// Opcode encoding shared by the bridge and its fabric, plus the bundled
// Wishbone-slave / C2F-request-response interface used as the bridge port.
package uart_wb_rc_pkg;
  typedef enum logic [1:0] {
    RD     = 2'b00,
    WR     = 2'b01,
    RD_RSP = 2'b10,
    WR_RSP = 2'b11
  } t_opcode;
endpackage

interface uart_wb_rc_bridge_if;
  import uart_wb_rc_pkg::*;

  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        wb_err_o;

  logic        C2F_ReqValidQ500H;
  t_opcode     C2F_ReqOpcodeQ500H;
  logic [31:0] C2F_ReqAddressQ500H;
  logic [31:0] C2F_ReqDataQ500H;
  logic [1:0]  C2F_ReqThreadIDQ500H;
  logic        C2F_RspValidQ502H;
  t_opcode     C2F_RspOpcodeQ502H;
  logic [31:0] C2F_RspDataQ502H;
  logic [1:0]  C2F_RspThreadIDQ502H;
  logic        C2F_RspStall;

  // Bridge side: Wishbone slave toward the gateway, request master toward the ring.
  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
    output wb_dat_o, wb_ack_o, wb_err_o,
    output C2F_ReqValidQ500H, C2F_ReqOpcodeQ500H, C2F_ReqAddressQ500H,
           C2F_ReqDataQ500H, C2F_ReqThreadIDQ500H,
    input  C2F_RspValidQ502H, C2F_RspOpcodeQ502H, C2F_RspDataQ502H,
           C2F_RspThreadIDQ502H, C2F_RspStall
  );

  // Environment side: the gateway master plus the ring fabric.
  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
    input  wb_dat_o, wb_ack_o, wb_err_o,
    input  C2F_ReqValidQ500H, C2F_ReqOpcodeQ500H, C2F_ReqAddressQ500H,
           C2F_ReqDataQ500H, C2F_ReqThreadIDQ500H,
    output C2F_RspValidQ502H, C2F_RspOpcodeQ502H, C2F_RspDataQ502H,
           C2F_RspThreadIDQ502H, C2F_RspStall
  );
endinterface

// File: rtl/uart_wb_rc_bridge.sv
// Wishbone slave to C2F ring bridge: one outstanding transaction, thread-ID
// matched responses, bounded wait with error termination.
module uart_wb_rc_bridge
  import uart_wb_rc_pkg::*;
#(
  parameter logic [1:0] THREAD_ID      = 2'd0,
  parameter int         TIMEOUT_CYCLES = 1023
) (
  input  logic                 clk,
  input  logic                 rstn,
  uart_wb_rc_bridge_if.slave   bus
);

  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 10) ? $clog2(TIMEOUT_CYCLES + 1) : 10;
  localparam logic [CNT_W:0] C_TMO = (CNT_W + 1)'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, ACK, ERR, DRAIN} t_state;

  t_state           r_state;
  logic             r_we;
  logic [31:0]      r_adr;
  logic [31:0]      r_dat;
  logic [31:0]      r_rdat;
  logic [1:0]       r_tid;
  logic             r_ack;
  logic             r_err;
  logic [CNT_W-1:0] r_cnt;

  logic w_match;
  logic w_tmo;

  assign w_match = bus.C2F_RspValidQ502H &&
                   (bus.C2F_RspThreadIDQ502H == THREAD_ID) &&
                   (bus.C2F_RspOpcodeQ502H == (r_we ? WR_RSP : RD_RSP));
  // Expiry fires in the cycle that would be the TIMEOUT_CYCLES-th wait cycle.
  assign w_tmo   = ({1'b0, r_cnt} + (CNT_W + 1)'(1)) >= C_TMO;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_we    <= 1'b0;
      r_adr   <= '0;
      r_dat   <= '0;
      r_rdat  <= '0;
      r_tid   <= '0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      case (r_state)
        IDLE: begin
          r_rdat <= '0;
          if (bus.wb_cyc_i && bus.wb_stb_i) begin
            if (bus.wb_sel_i != 4'hF) begin
              r_state <= ERR;
              r_err   <= 1'b1;
              r_rdat  <= 32'hDEAD_BEEF;
            end else begin
              r_state <= ISSUE;
              r_we    <= bus.wb_we_i;
              r_adr   <= bus.wb_adr_i;
              r_dat   <= bus.wb_we_i ? bus.wb_dat_i : 32'h0;
              r_tid   <= THREAD_ID;
            end
          end
        end
        ISSUE: begin
          if (!bus.wb_cyc_i) begin
            r_state <= IDLE;
          end else if (!bus.C2F_RspStall) begin
            r_state <= WAIT;
            r_cnt   <= '0;
          end
        end
        WAIT: begin
          // An abandoned cycle still has a response in flight; soak it up in DRAIN.
          if (!bus.wb_cyc_i) begin
            r_state <= DRAIN;
            r_cnt   <= r_cnt + CNT_W'(1);
          end else if (w_match) begin
            r_state <= ACK;
            r_ack   <= 1'b1;
            r_rdat  <= r_we ? 32'h0 : bus.C2F_RspDataQ502H;
          end else if (w_tmo) begin
            r_state <= ERR;
            r_err   <= 1'b1;
            r_rdat  <= 32'hDEAD_BEEF;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        DRAIN: begin
          if (w_match || w_tmo) r_state <= IDLE;
          else                  r_cnt   <= r_cnt + CNT_W'(1);
        end
        ACK, ERR: r_state <= IDLE;
        default:  r_state <= IDLE;
      endcase
    end
  end

  // Request valid follows stall combinationally so a stalled request is held, never lost.
  assign bus.C2F_ReqValidQ500H    = (r_state == ISSUE) && bus.wb_cyc_i && !bus.C2F_RspStall;
  assign bus.C2F_ReqOpcodeQ500H   = r_we ? WR : RD;
  assign bus.C2F_ReqAddressQ500H  = r_adr;
  assign bus.C2F_ReqDataQ500H     = r_dat;
  assign bus.C2F_ReqThreadIDQ500H = r_tid;
  assign bus.wb_dat_o             = r_rdat;
  assign bus.wb_ack_o             = r_ack;
  assign bus.wb_err_o             = r_err;

endmodule

// File: tb/tb_uart_wb_rc_bridge.sv
// Directed scoreboard bench for uart_wb_rc_bridge (THREAD_ID=1, TIMEOUT_CYCLES=8).
module tb_uart_wb_rc_bridge;
  import uart_wb_rc_pkg::*;

  localparam logic [1:0] TID = 2'd1;

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   n;

  logic [67:0] req_q[$];
  logic [33:0] rsp_q[$];

  uart_wb_rc_bridge_if bus();

  uart_wb_rc_bridge #(.THREAD_ID(TID), .TIMEOUT_CYCLES(8)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step; @(posedge clk); #1; endtask
  task automatic look; @(negedge clk); endtask

  task automatic wb_start(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel);
    bus.wb_we_i = we; bus.wb_adr_i = adr; bus.wb_dat_i = dat; bus.wb_sel_i = sel;
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1;
  endtask

  task automatic wb_end;
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
  endtask

  task automatic rsp_on(input t_opcode op, input logic [1:0] tid, input logic [31:0] d);
    bus.C2F_RspOpcodeQ502H = op; bus.C2F_RspThreadIDQ502H = tid;
    bus.C2F_RspDataQ502H = d; bus.C2F_RspValidQ502H = 1'b1;
  endtask

  task automatic rsp_off; bus.C2F_RspValidQ502H = 1'b0; endtask

  task automatic exp_req(input t_opcode op, input logic [31:0] adr, input logic [31:0] dat);
    req_q.push_back({op, adr, dat, TID});
  endtask

  task automatic exp_rsp(input logic ack, input logic [31:0] d);
    rsp_q.push_back({ack, ~ack, d});
  endtask

  function automatic logic [102:0] all_outs();
    return {bus.wb_ack_o, bus.wb_err_o, bus.wb_dat_o, bus.C2F_ReqValidQ500H,
            bus.C2F_ReqOpcodeQ500H, bus.C2F_ReqAddressQ500H, bus.C2F_ReqDataQ500H,
            bus.C2F_ReqThreadIDQ500H};
  endfunction

  // Full write transaction with latency checks; response data must not leak into wb_dat_o.
  task automatic do_write(input string tag, input logic [31:0] adr, input logic [31:0] dat);
    step; wb_start(1'b1, adr, dat, 4'hF);
    exp_req(WR, adr, dat); exp_rsp(1'b1, 32'h0);
    look; chk({tag, "_idle_novld"}, 128'(bus.C2F_ReqValidQ500H), 128'(0));
    step; look; chk({tag, "_req_n1"}, 128'(bus.C2F_ReqValidQ500H), 128'(1));
    step; look; chk({tag, "_req_once"}, 128'(bus.C2F_ReqValidQ500H), 128'(0));
    step; rsp_on(WR_RSP, TID, 32'hFFFF_0000);
    look; chk({tag, "_no_early_ack"}, 128'(bus.wb_ack_o), 128'(0));
    step; rsp_off;
    look; chk({tag, "_ack_m1"}, 128'(bus.wb_ack_o), 128'(1));
    chk({tag, "_no_err"}, 128'(bus.wb_err_o), 128'(0));
    step; wb_end;
  endtask

  // Scoreboard monitor: every request and every completion must have been expected.
  always @(negedge clk) begin
    if (rstn) begin
      chk("ack_err_exclusive", 128'(bus.wb_ack_o & bus.wb_err_o), 128'(0));
      if (bus.C2F_ReqValidQ500H) begin
        chk("req_expected", 128'(req_q.size() != 0), 128'(1));
        if (req_q.size() != 0)
          chk("req_fields", 128'({bus.C2F_ReqOpcodeQ500H, bus.C2F_ReqAddressQ500H,
                                  bus.C2F_ReqDataQ500H, bus.C2F_ReqThreadIDQ500H}),
              128'(req_q.pop_front()));
      end
      if (bus.wb_ack_o || bus.wb_err_o) begin
        chk("cpl_expected", 128'(rsp_q.size() != 0), 128'(1));
        if (rsp_q.size() != 0)
          chk("cpl_fields", 128'({bus.wb_ack_o, bus.wb_err_o, bus.wb_dat_o}),
              128'(rsp_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
    bus.wb_adr_i = '0; bus.wb_dat_i = '0; bus.wb_sel_i = 4'h0;
    bus.C2F_RspValidQ502H = 1'b0; bus.C2F_RspOpcodeQ502H = RD_RSP;
    bus.C2F_RspDataQ502H = '0; bus.C2F_RspThreadIDQ502H = '0; bus.C2F_RspStall = 1'b0;

    // Asynchronous reset before any clock edge.
    #1 rstn = 1'b0;
    #2 chk("reset_outputs", 128'(all_outs()), 128'(0));
    step; step; rstn = 1'b1;

    // Plain write.
    do_write("wr", 32'h0040_0100, 32'h1234_5678);

    // Read stalled for three ISSUE cycles.
    bus.C2F_RspStall = 1'b1;
    step; wb_start(1'b0, 32'h0040_0200, 32'hAAAA_5555, 4'hF);
    exp_req(RD, 32'h0040_0200, 32'h0); exp_rsp(1'b1, 32'hCAFE_F00D);
    for (int i = 0; i < 3; i++) begin
      step; look; chk("stall_hold", 128'(bus.C2F_ReqValidQ500H), 128'(0));
    end
    step; bus.C2F_RspStall = 1'b0;
    look; chk("stall_req_4th", 128'(bus.C2F_ReqValidQ500H), 128'(1));
    step; rsp_on(RD_RSP, TID, 32'hCAFE_F00D);
    step; rsp_off;
    look; chk("rd_ack", 128'(bus.wb_ack_o), 128'(1));
    chk("rd_data", 128'(bus.wb_dat_o), 128'(32'hCAFE_F00D));
    step; wb_end;

    // Wrong thread and wrong opcode are ignored; the matching response acks once.
    step; wb_start(1'b0, 32'h0040_0300, 32'h0, 4'hF);
    exp_req(RD, 32'h0040_0300, 32'h0); exp_rsp(1'b1, 32'h0BAD_1D00);
    step; look; chk("thr_req", 128'(bus.C2F_ReqValidQ500H), 128'(1));
    step; rsp_on(RD_RSP, ~TID, 32'h1111_1111);
    step; rsp_off; look; chk("thr_bad_tid_ignored", 128'(bus.wb_ack_o), 128'(0));
    step; rsp_on(WR_RSP, TID, 32'h2222_2222);
    step; rsp_off; look; chk("thr_bad_op_ignored", 128'(bus.wb_ack_o), 128'(0));
    step; rsp_on(RD_RSP, TID, 32'h0BAD_1D00);
    step; rsp_off; look; chk("thr_ack", 128'(bus.wb_ack_o), 128'(1));
    step; wb_end;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      look; if (bus.wb_ack_o) n++;
      step;
    end
    chk("thr_single_ack", 128'(n), 128'(0));

    // Read with no response times out after 8 wait cycles.
    step; wb_start(1'b0, 32'h0040_0400, 32'h0, 4'hF);
    exp_req(RD, 32'h0040_0400, 32'h0); exp_rsp(1'b0, 32'hDEAD_BEEF);
    step; look; chk("tmo_req", 128'(bus.C2F_ReqValidQ500H), 128'(1));
    n = 0;
    do begin step; look; n++; end while (!bus.wb_err_o && !bus.wb_ack_o && n < 40);
    chk("tmo_cycles", 128'(n), 128'(9));
    chk("tmo_err", 128'(bus.wb_err_o), 128'(1));
    chk("tmo_data", 128'(bus.wb_dat_o), 128'(32'hDEAD_BEEF));
    step; wb_end;

    // Match arriving in the expiry cycle wins.
    step; wb_start(1'b0, 32'h0040_0500, 32'h0, 4'hF);
    exp_req(RD, 32'h0040_0500, 32'h0); exp_rsp(1'b1, 32'hBEEF_0008);
    step; look; chk("exp_req", 128'(bus.C2F_ReqValidQ500H), 128'(1));
    for (int i = 0; i < 7; i++) begin
      step; look; chk("exp_no_early_err", 128'(bus.wb_err_o), 128'(0));
    end
    step; rsp_on(RD_RSP, TID, 32'hBEEF_0008);
    step; rsp_off;
    look; chk("exp_ack", 128'(bus.wb_ack_o), 128'(1));
    chk("exp_no_err", 128'(bus.wb_err_o), 128'(0));
    step; wb_end;

    // Partial byte select is rejected without touching the fabric.
    step; wb_start(1'b1, 32'h0040_0600, 32'h0102_0304, 4'h3);
    exp_rsp(1'b0, 32'hDEAD_BEEF);
    step; look; chk("sel_err", 128'(bus.wb_err_o), 128'(1));
    chk("sel_no_req", 128'(bus.C2F_ReqValidQ500H), 128'(0));
    step; wb_end;
    look; chk("sel_idle_no_req", 128'(bus.C2F_ReqValidQ500H), 128'(0));

    // Cycle dropped while waiting: response drained silently, then back to normal.
    step; wb_start(1'b0, 32'h0040_0700, 32'h0, 4'hF);
    exp_req(RD, 32'h0040_0700, 32'h0);
    step; look; chk("drain_req", 128'(bus.C2F_ReqValidQ500H), 128'(1));
    step; wb_end;
    step; rsp_on(RD_RSP, TID, 32'h7777_7777);
    step; rsp_off;
    look; chk("drain_no_cpl", 128'({bus.wb_ack_o, bus.wb_err_o}), 128'(0));
    do_write("post_drain", 32'h0040_0800, 32'h8888_0001);

    // Reset in WAIT: outputs clear immediately, late response ignored.
    step; wb_start(1'b0, 32'h0040_0900, 32'h0, 4'hF);
    exp_req(RD, 32'h0040_0900, 32'h0);
    step; look; chk("rstw_req", 128'(bus.C2F_ReqValidQ500H), 128'(1));
    step; look;
    #1 rstn = 1'b0;
    #1 chk("rstw_outputs", 128'(all_outs()), 128'(0));
    wb_end;
    step; rstn = 1'b1;
    step; rsp_on(RD_RSP, TID, 32'h5555_5555);
    step; rsp_off;
    look; chk("rstw_late_no_ack", 128'({bus.wb_ack_o, bus.wb_err_o}), 128'(0));
    do_write("post_rst", 32'h0040_0A00, 32'h0A0A_0A0A);

    step; step;
    chk("req_q_drained", 128'(req_q.size()), 128'(0));
    chk("rsp_q_drained", 128'(rsp_q.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_wb_rc_bridge.md
UART_WB_RC_BRIDGE -- requirements
Module: uart_wb_rc_bridge

Interface
REQ-001 The block SHALL have parameter THREAD_ID, default 2'd0, the thread ID placed on every C2F request and matched on responses.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 1023, the maximum number of WAIT cycles before an error termination.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset, with ports as follows.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rstn  in  1  asynchronous active-low reset.
REQ-006 wb_cyc_i  in  1  Wishbone cycle from the gateway master.
REQ-007 wb_stb_i  in  1  Wishbone strobe.
REQ-008 wb_we_i  in  1  1 = write, 0 = read.
REQ-009 wb_adr_i  in  32  target address on the ring.
REQ-010 wb_dat_i  in  32  write data.
REQ-011 wb_sel_i  in  4  byte selects.
REQ-012 wb_dat_o  out  32  read data, valid while wb_ack_o or wb_err_o is high.
REQ-013 wb_ack_o  out  1  one-cycle successful completion.
REQ-014 wb_err_o  out  1  one-cycle error completion.
REQ-015 C2F_ReqValidQ500H  out  1  request valid.
REQ-016 C2F_ReqOpcodeQ500H  out  t_opcode  RD or WR.
REQ-017 C2F_ReqAddressQ500H  out  32  request address.
REQ-018 C2F_ReqDataQ500H  out  32  write data; 0 for RD.
REQ-019 C2F_ReqThreadIDQ500H  out  2  equals THREAD_ID.
REQ-020 C2F_RspValidQ502H  in  1  response valid.
REQ-021 C2F_RspOpcodeQ502H  in  t_opcode  RD_RSP or WR_RSP.
REQ-022 C2F_RspDataQ502H  in  32  read response data.
REQ-023 C2F_RspThreadIDQ502H  in  2  response thread ID.
REQ-024 C2F_RspStall  in  1  fabric cannot accept a request this cycle.

Function
REQ-025 The FSM SHALL have the states IDLE, ISSUE, WAIT, ACK, ERR and DRAIN.
REQ-026 IDLE: on wb_cyc_i & wb_stb_i, the block SHALL capture we/adr/dat and enter ISSUE; if wb_sel_i != 4'hF, it SHALL enter ERR directly and issue no fabric request.
REQ-027 ISSUE: with C2F_RspStall=0, the block SHALL assert C2F_ReqValidQ500H for exactly one cycle with the captured fields, then enter WAIT.
REQ-028 ISSUE: with C2F_RspStall=1, the block SHALL hold C2F_ReqValidQ500H=0 and remain in ISSUE (no request is ever dropped).
REQ-029 ISSUE: if wb_cyc_i deasserts before the request is issued, the block SHALL return to IDLE with no request issued.
REQ-030 WAIT: a response SHALL match only if C2F_RspValidQ502H=1, C2F_RspThreadIDQ502H=THREAD_ID, and the opcode is RD_RSP for a read or WR_RSP for a write; non-matching responses SHALL be ignored.
REQ-031 WAIT: on a match, the block SHALL register wb_dat_o (C2F_RspDataQ502H for a read, 32'h0 for a write) and enter ACK.
REQ-032 WAIT: the timeout counter (10 bits minimum, cleared on entry to WAIT) SHALL increment each cycle; on reaching TIMEOUT_CYCLES the block SHALL enter ERR.
REQ-033 A match in the same cycle as timeout expiry SHALL take precedence, giving ACK.
REQ-034 WAIT: if wb_cyc_i deasserts, the block SHALL enter DRAIN; DRAIN SHALL return to IDLE on a match or on timeout, with no ack or err.
REQ-035 ACK SHALL assert wb_ack_o for one cycle, and ERR SHALL assert wb_err_o for one cycle with wb_dat_o=32'hDEAD_BEEF; both SHALL then return to IDLE.
REQ-036 Only one transaction SHALL be outstanding at a time; wb_stb_i SHALL be ignored outside IDLE.
REQ-037 Latency: strobe sampled in IDLE at cycle N gives request valid at N+1 (no stall); a matching response at cycle M gives wb_ack_o at M+1.
REQ-038 wb_ack_o and wb_err_o SHALL never be high together.

Reset
REQ-039 On rstn=0, the FSM SHALL go to IDLE, the counter and captured fields SHALL clear, and all outputs SHALL be 0 (opcode RD encoding), asynchronously.
REQ-040 A response for a transaction pending before reset SHALL be ignored, because responses are not examined in IDLE.

Verification
REQ-041 The bench SHALL run a write of adr 32'h0040_0100, dat 32'h1234_5678, sel F -> WR request at N+1; WR_RSP at M -> wb_ack_o at M+1, no err.
REQ-042 The bench SHALL run a read of adr 32'h0040_0200 with C2F_RspStall high for 3 cycles -> request valid on the 4th ISSUE cycle; RD_RSP data 32'hCAFE_F00D -> wb_dat_o=32'hCAFE_F00D with ack.
REQ-043 The bench SHALL send a read followed by an RD_RSP with thread ID != THREAD_ID, then a matching RD_RSP -> the first is ignored and exactly one ack follows the second.
REQ-044 The bench SHALL send a read with no response and TIMEOUT_CYCLES=8 -> wb_err_o after 8 WAIT cycles, wb_dat_o=32'hDEAD_BEEF; it SHALL also check that a match in the expiry cycle gives ack.
REQ-045 The bench SHALL drive sel=4'h3 -> wb_err_o, no C2F request; it SHALL also drop cyc in WAIT, then send the response -> no ack and a return to IDLE.
REQ-046 The bench SHALL pulse rstn low in WAIT -> outputs 0 immediately; a late response produces no ack; the next transaction completes normally.
